imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream of the single-cycle core top: receives a program as a byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit little-endian words and writes them sequentially into instruction memory from byte address 0.
- Holds the core in reset for the whole load, then releases it so the core starts executing the freshly loaded program.
- Replaces the hard-coded memfile preload for board bring-up.

Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in words; maximum legal load_len.
- LEN_W, 7, width of load_len; must satisfy 2**LEN_W > DEPTH_WORDS.
- RELEASE_CYC, 2, cycles core_reset stays high after the last write before release.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low block reset.
- load_start  in  1  single-cycle request to begin a load.
- load_len  in  LEN_W  number of words to load; sampled with load_start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  32  byte address, always word aligned.
- imem_wdata  out  32  assembled instruction word.
- core_reset  out  1  active-high reset to core top.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the core is released.
- err  out  1  sticky protocol error flag.

Behaviour:
- All outputs are registered; all state updates on the rising clk edge.
- Reset (reset==0 at an edge):
  - state=IDLE, byte_cnt=0, word_cnt=0.
  - core_reset=1, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0.
  - Reset mid-load aborts the load with no further writes. Memory keeps whatever was already written.
- The core stays in reset after power-up until a load completes.

IDLE:
- byte_ready=0, busy=0. core_reset keeps its last value (0 after a completed load).
- load_start with 1 <= load_len <= DEPTH_WORDS:
  - latch len, clear counters and err.
  - core_reset=1, busy=1, go to RECV.
- load_start with load_len==0 or load_len>DEPTH_WORDS: err=1, stay in IDLE, core_reset unchanged.

RECV:
- byte_ready=1. A byte is accepted on an edge where byte_valid && byte_ready.
- Accepted byte k (k=0..3) goes to word bits [8k+7:8k]; byte_cnt increments.
- byte_valid while byte_ready=0 is not consumed and does not advance anything.
- The 4th accept (byte_cnt==3) moves to WRITE on that edge, with byte_ready=0 from the next cycle.

WRITE (exactly one cycle):
- imem_we=1, imem_addr=word_cnt*4, imem_wdata=assembled word.
- The write is visible the cycle after the edge that accepted the 4th byte.
- Then word_cnt increments. If word_cnt+1==len, go to RELEASE; else go back to RECV with byte_cnt=0.

RELEASE:
- imem_we=0, core_reset=1 for RELEASE_CYC cycles.
- Then core_reset=0, done=1 for one cycle, busy=0, return to IDLE.

Boundaries and simultaneous events:
- load_start while busy is ignored and sets err=1; the ongoing load continues unaffected.
- load_start in IDLE while the core is running re-asserts core_reset at the next edge.
- err clears only on reset or on an accepted legal load_start.
- word_cnt never exceeds len-1; imem_addr never exceeds (DEPTH_WORDS-1)*4.
- A byte stream that stalls (byte_valid low) holds the state indefinitely; there is no timeout.

Decomposition:
- Package boot_loader_pkg:
  - typedef enum logic [1:0] {IDLE, RECV, WRITE, RELEASE} loader_state_t.
  - localparam BYTES_PER_WORD=4.
  - localparam WORD_ADDR_SHIFT=2.
- Sub-module byte_word_assembler:
  - shift/insert register plus 2-bit byte_cnt.
  - outputs word and word_full.
  - inputs: accept strobe and clear.
- FSM, word counter and output registers stay in imem_boot_loader.

Test Plan:
- Hold reset=0 for 3 cycles -> core_reset=1, byte_ready=0, imem_we=0, busy=0, done=0, err=0 throughout.
- load_start, load_len=2; bytes 13,01,50,00 then 23,22,30,06 with byte_valid always high -> imem_we pulses:
  - addr 0x0, data 0x00500113;
  - addr 0x4, data 0x06302223;
  - core_reset stays high 2 cycles after the second write, then falls with a one-cycle done pulse.
- Same load with byte_valid toggled 1,0,0,1 and 3-cycle gaps -> identical writes and data, no extra imem_we, byte_ready stays high while waiting in RECV.
- load_len=0, then load_len=65 -> err=1, busy=0, no writes. A following legal load_len=1 clears err and completes.
- load_start pulsed mid-load after 2 bytes -> err=1, load completes with correct words. reset=0 after word 0 written -> state IDLE, no write to addr 0x4, core_reset=1.
- load_len=64 with incrementing bytes 00..FF repeating -> 64 writes:
  - last write at addr 0xFC, data 0xFFFEFDFC;
  - no write beyond 0xFC.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Provides the loader FSM state type and word/byte geometry.
package boot_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    RELEASE
  } loader_state_t;

  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_ADDR_SHIFT = 2;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word.
// Ports: clk, reset (sync, active-low), accept, clear, byte_data -> word, word_full.
module byte_word_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] word_q;
  logic [1:0]  byte_cnt;

  // word already includes the byte being accepted this cycle, so the
  // caller can register the complete word on the 4th accept edge.
  always_comb begin
    word = word_q;
    if (accept) begin
      word[{byte_cnt, 3'b000} +: 8] = byte_data;
    end
  end

  assign word_full = accept &&
    (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      word_q   <= word;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a byte stream into instruction memory and holds the core in reset meanwhile.
// Ports: load_start/load_len, byte stream handshake, imem write port, core_reset, busy, done, err.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LEN_W       = 7,
  parameter int RELEASE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RC_W = $clog2(RELEASE_CYC + 1);

  loader_state_t    state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;
  logic [RC_W-1:0]  rel_cnt;

  logic        len_ok;
  logic        start_ok;
  logic        accept;
  logic        asm_clear;
  logic [31:0] word;
  logic        word_full;

  assign len_ok = (load_len != '0) &&
    (load_len <= LEN_W'(DEPTH_WORDS));
  assign start_ok  = (state == IDLE) && load_start && len_ok;
  assign accept    = byte_valid && byte_ready;
  assign asm_clear = start_ok || (state == WRITE);

  byte_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .clear     (asm_clear),
    .byte_data (byte_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      len        <= '0;
      word_cnt   <= '0;
      rel_cnt    <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      // a request during an ongoing load is refused but flagged
      if (load_start && state != IDLE) begin
        err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (load_start) begin
            if (len_ok) begin
              len        <= load_len;
              word_cnt   <= '0;
              err        <= 1'b0;
              core_reset <= 1'b1;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              state      <= RECV;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (word_full) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= 32'(word_cnt) << WORD_ADDR_SHIFT;
            imem_wdata <= word;
            state      <= WRITE;
          end
        end
        WRITE: begin
          imem_we  <= 1'b0;
          word_cnt <= word_cnt + LEN_W'(1);
          if (word_cnt + LEN_W'(1) == len) begin
            rel_cnt <= '0;
            state   <= RELEASE;
          end else begin
            byte_ready <= 1'b1;
            state      <= RECV;
          end
        end
        RELEASE: begin
          if (rel_cnt == RC_W'(RELEASE_CYC - 1)) begin
            core_reset <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            rel_cnt <= rel_cnt + RC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader.
// Drives byte streams and compares imem writes against a word-packing model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [6:0]  load_len = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;

  imem_boot_loader #(
    .DEPTH_WORDS (64),
    .LEN_W       (7),
    .RELEASE_CYC (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int cyc = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      last_we_cyc = cyc;
      total++;
      if (imem_addr > 32'hFC || imem_addr[1:0] != 2'b00) begin
        bad++;
        $display("FAIL addr_range: got %h want <=fc aligned", imem_addr);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) begin
      total++;
      if (core_reset !== 1'b1) begin
        bad++;
        $display("FAIL core_held: got core_reset=%b want 1", core_reset);
      end
    end
  end

  function automatic logic [31:0] model_word(input logic [7:0] b[$], input int w);
    return {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
  endfunction

  task automatic start_load(input int len);
    load_len = 7'(len);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap, input bit chk);
    bit hs;
    int n;
    byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (chk) begin
        total++;
        if (byte_ready !== 1'b1) begin
          bad++;
          $display("FAIL ready_wait: got %b want 1", byte_ready);
        end
      end
      @(posedge clk); #1;
    end
    byte_data = b;
    byte_valid = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = byte_ready;
      @(posedge clk); #1;
      n++;
    end
    byte_valid = 1'b0;
    if (!hs) begin
      bad++;
      $display("FAIL byte_timeout: got ready=0 want 1");
    end
  endtask

  task automatic send_stream(input logic [7:0] b[$], input int g[$]);
    for (int k = 0; k < b.size(); k++) begin
      push_byte(b[k], (g.size() > k) ? g[k] : 0, (k == 0) || (k % 4 != 0));
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({core_reset, byte_ready, imem_we, busy, done, err} !== 6'b100000) begin
        bad++;
        $display("FAIL reset_outs: got cr=%b rdy=%b we=%b busy=%b done=%b err=%b want 100000",
                 core_reset, byte_ready, imem_we, busy, done, err);
      end
      total++;
      if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
        bad++;
        $display("FAIL reset_bus: got addr=%h data=%h want 0", imem_addr, imem_wdata);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_basic;
    logic [7:0] b[$];
    int g[$];
    int d0;
    bit ok;
    b = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h23, 8'h22, 8'h30, 8'h06};
    g = {};
    wa.delete(); wd.delete();
    d0 = done_cnt;
    start_load(2);
    send_stream(b, g);
    wait_done(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_done: got none want pulse"); end
    total++;
    if (wa.size() != 2) begin
      bad++;
      $display("FAIL basic_count: got %0d want 2", wa.size());
    end else begin
      total++;
      if (wa[0] !== 32'h0 || wd[0] !== 32'h00500113) begin
        bad++;
        $display("FAIL basic_w0: got %h/%h want 0/00500113", wa[0], wd[0]);
      end
      total++;
      if (wa[1] !== 32'h4 || wd[1] !== 32'h06302223) begin
        bad++;
        $display("FAIL basic_w1: got %h/%h want 4/06302223", wa[1], wd[1]);
      end
    end
    total++;
    if (done_cyc - last_we_cyc != 3) begin
      bad++;
      $display("FAIL release_delay: got %0d want 3", done_cyc - last_we_cyc);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt - d0);
    end
    total++;
    if (core_reset !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL basic_end: got cr=%b busy=%b done=%b want 000", core_reset, busy, done);
    end
  endtask

  task automatic test_gaps;
    logic [7:0] b[$];
    int g[$];
    bit ok;
    b = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h23, 8'h22, 8'h30, 8'h06};
    g = '{0, 2, 0, 3, 3, 0, 3, 1};
    wa.delete(); wd.delete();
    start_load(2);
    total++;
    if (core_reset !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rehold: got cr=%b busy=%b want 11", core_reset, busy);
    end
    send_stream(b, g);
    wait_done(ok);
    total++;
    if (!ok || wa.size() != 2) begin
      bad++;
      $display("FAIL gaps_count: got %0d writes done=%b want 2/1", wa.size(), ok);
    end else begin
      for (int w = 0; w < 2; w++) begin
        total++;
        if (wa[w] !== 32'(4*w) || wd[w] !== model_word(b, w)) begin
          bad++;
          $display("FAIL gaps_w%0d: got %h/%h want %h/%h", w, wa[w], wd[w], 4*w, model_word(b, w));
        end
      end
    end
  endtask

  task automatic test_bad_len;
    logic [7:0] b[$];
    int g[$];
    bit ok;
    int lens[2];
    lens = '{0, 65};
    wa.delete(); wd.delete();
    foreach (lens[i]) begin
      start_load(lens[i]);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (err !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || core_reset !== 1'b0) begin
        bad++;
        $display("FAIL bad_len%0d: got err=%b busy=%b rdy=%b cr=%b want 1000",
                 lens[i], err, busy, byte_ready, core_reset);
      end
    end
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL bad_len_writes: got %0d want 0", wa.size());
    end
    b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    g = {};
    start_load(1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    send_stream(b, g);
    wait_done(ok);
    total++;
    if (!ok || wa.size() != 1 || wd[0] !== 32'hDEADBEEF || wa[0] !== 32'h0) begin
      bad++;
      $display("FAIL len1: got n=%0d done=%b want one write deadbeef@0", wa.size(), ok);
    end
  endtask

  task automatic test_overlap;
    logic [7:0] b[$];
    int g[$];
    bit ok;
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    g = {};
    wa.delete(); wd.delete();
    start_load(2);
    push_byte(b[0], 0, 1'b1);
    push_byte(b[1], 0, 1'b1);
    start_load(5);
    total++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL overlap_err: got err=%b busy=%b want 11", err, busy);
    end
    for (int k = 2; k < 8; k++) push_byte(b[k], 0, 1'b0);
    wait_done(ok);
    total++;
    if (!ok || wa.size() != 2) begin
      bad++;
      $display("FAIL overlap_count: got %0d done=%b want 2/1", wa.size(), ok);
    end else begin
      for (int w = 0; w < 2; w++) begin
        total++;
        if (wa[w] !== 32'(4*w) || wd[w] !== model_word(b, w)) begin
          bad++;
          $display("FAIL overlap_w%0d: got %h/%h want %h/%h", w, wa[w], wd[w], 4*w, model_word(b, w));
        end
      end
    end
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b[$];
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    wa.delete(); wd.delete();
    start_load(2);
    for (int k = 0; k < 4; k++) push_byte(b[k], 0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    total++;
    if (busy !== 1'b0 || core_reset !== 1'b1 || byte_ready !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b cr=%b rdy=%b err=%b want 0100",
               busy, core_reset, byte_ready, err);
    end
    byte_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    total++;
    if (wa.size() != 1 || wd[0] !== model_word(b, 0)) begin
      bad++;
      $display("FAIL mid_writes: got %0d writes want 1 (word0 only)", wa.size());
    end
    total++;
    if (busy !== 1'b0 || core_reset !== 1'b1) begin
      bad++;
      $display("FAIL mid_idle: got busy=%b cr=%b want 01", busy, core_reset);
    end
  endtask

  task automatic test_full;
    logic [7:0] b[$];
    int g[$];
    bit ok;
    int errs;
    for (int i = 0; i < 256; i++) b.push_back(8'(i));
    g = {};
    wa.delete(); wd.delete();
    start_load(64);
    send_stream(b, g);
    wait_done(ok);
    total++;
    if (!ok || wa.size() != 64) begin
      bad++;
      $display("FAIL full_count: got %0d done=%b want 64/1", wa.size(), ok);
    end else begin
      total++;
      if (wa[63] !== 32'hFC || wd[63] !== 32'hFFFEFDFC) begin
        bad++;
        $display("FAIL full_last: got %h/%h want fc/fffefdfc", wa[63], wd[63]);
      end
      errs = 0;
      for (int w = 0; w < 64; w++)
        if (wa[w] !== 32'(4*w) || wd[w] !== model_word(b, w)) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL full_words: got %0d wrong want 0", errs);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] b[$];
    int g[$];
    bit ok;
    int len;
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(1, 6);
      b.delete(); g.delete();
      for (int i = 0; i < 4*len; i++) begin
        b.push_back(8'($urandom));
        g.push_back($urandom_range(0, 2));
      end
      wa.delete(); wd.delete();
      start_load(len);
      send_stream(b, g);
      wait_done(ok);
      total++;
      if (!ok || wa.size() != len) begin
        bad++;
        $display("FAIL rand%0d_count: got %0d done=%b want %0d", it, wa.size(), ok, len);
      end else begin
        for (int w = 0; w < len; w++) begin
          total++;
          if (wa[w] !== 32'(4*w) || wd[w] !== model_word(b, w)) begin
            bad++;
            $display("FAIL rand%0d_w%0d: got %h/%h want %h/%h",
                     it, w, wa[w], wd[w], 4*w, model_word(b, w));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bad_len();
    test_overlap();
    test_reset_mid();
    test_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
